// File: rtl/i8254_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// i8254_bus_master_pkg
// Shared definitions for the 8254 host-side bus initiator:
//   - bus-sequencer state encodings
//   - {A1,A0} register address constants
//   - phase-length limit and the illegal-request check
// No ports (package).
// ---------------------------------------------------------------------------
package i8254_bus_master_pkg;

  // Bus sequencer states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  // {A1,A0}: 0..2 select counters 0..2, 3 selects the control word
  localparam logic [1:0] ADDR_CNT0 = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // Phase counter is 4 bits wide, so no phase may last longer than this
  localparam int PHASE_MAX = 15;

  // The control word is write-only and exactly one byte wide
  function automatic logic is_illegal(input logic write, input logic [1:0] addr,
                                      input logic len16);
    return (addr == ADDR_CTRL) && (!write || len16);
  endfunction

endpackage

// File: rtl/i8254_phase_timer.sv
// ---------------------------------------------------------------------------
// i8254_phase_timer
// Down-counter that times one bus phase. The sequencer pulses 'start' with
// N-1 on the edge that enters a phase; 'done' is high during the last cycle
// of that phase (count has reached zero).
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   async active-low reset
//   start     in   load load_val on this edge
//   load_val  in   4-bit phase length minus one
//   done      out  current phase is in its final cycle
// ---------------------------------------------------------------------------
module i8254_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] count;

  // Counts down to zero and parks there; a new load always wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (start) begin
      count <= load_val;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/i8254_bus_master.sv
// ---------------------------------------------------------------------------
// i8254_bus_master
// Host-side bus initiator for the 8254 timer. Turns a valid/ready request into
// a CPU-style read or write cycle (CS_n, A1:A0, RD_n, WR_n, D[7:0]) with
// programmable setup / strobe / hold / recovery lengths. A 16-bit access is
// two byte cycles, LSB then MSB, matching the 8254 RW=11 access mode.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake, accepted when both high at clk
//   req_write             1 = write, 0 = read
//   req_addr              {A1,A0}
//   req_len16             1 = two byte cycles (LSB then MSB)
//   req_wdata             write data ([7:0] only for 8-bit access)
//   resp_valid            one-cycle completion pulse
//   resp_rdata            read data ([15:8] = 0 for 8-bit access)
//   resp_err              illegal request flag, valid with resp_valid
//   cs_n, rd_n, wr_n      active-low bus strobes
//   a                     {A1,A0} to the chip
//   d_out, d_oe           write data and its drive enable
//   d_in                  read data from the chip
// ---------------------------------------------------------------------------
module i8254_bus_master
  import i8254_bus_master_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int RECOV_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic        req_len16,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic [1:0]  a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in
);

  // Phase lengths must fit the 4-bit phase counter and be at least one cycle
  generate
    if (SETUP_CYC < 1 || SETUP_CYC > PHASE_MAX ||
        STROBE_CYC < 1 || STROBE_CYC > PHASE_MAX ||
        HOLD_CYC < 1 || HOLD_CYC > PHASE_MAX ||
        RECOV_CYC < 1 || RECOV_CYC > PHASE_MAX) begin : g_bad_param
      $error("i8254_bus_master: phase lengths must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOV_LD  = 4'(RECOV_CYC - 1);

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        timer_start;
  logic [3:0]  timer_load;
  logic        timer_done;

  logic        accept;
  logic        illegal_req;
  logic        more_bytes;
  logic        last_byte_done;
  logic        bus_active;

  logic        write_q;
  logic [1:0]  addr_q;
  logic        len16_q;
  logic [15:0] wdata_q;
  logic        byte_sel;

  i8254_phase_timer u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (timer_start),
    .load_val (timer_load),
    .done     (timer_done)
  );

  assign req_ready   = (state == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign illegal_req = is_illegal(req_write, req_addr, req_len16);

  // A 16-bit access still owes its MSB byte while byte_sel is 0
  assign more_bytes     = len16_q && !byte_sel;
  assign last_byte_done = (state == ST_RECOVER) && timer_done && !more_bytes;

  // Phase sequencing: every phase transition also reloads the timer with the
  // length of the phase being entered. Illegal requests never leave IDLE.
  always_comb begin
    next_state  = state;
    timer_start = 1'b0;
    timer_load  = SETUP_LD;
    case (state)
      ST_IDLE: begin
        if (accept && !illegal_req) begin
          next_state  = ST_SETUP;
          timer_start = 1'b1;
          timer_load  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          next_state  = ST_STROBE;
          timer_start = 1'b1;
          timer_load  = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (timer_done) begin
          next_state  = ST_HOLD;
          timer_start = 1'b1;
          timer_load  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (timer_done) begin
          next_state  = ST_RECOVER;
          timer_start = 1'b1;
          timer_load  = RECOV_LD;
        end
      end
      ST_RECOVER: begin
        if (timer_done) begin
          if (more_bytes) begin
            next_state  = ST_SETUP;
            timer_start = 1'b1;
            timer_load  = SETUP_LD;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request capture. Illegal requests are not latched so the address lines
  // keep their previous value and the bus stays completely quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      addr_q   <= ADDR_CNT0;
      len16_q  <= 1'b0;
      wdata_q  <= 16'h0000;
      byte_sel <= 1'b0;
    end else if (accept && !illegal_req) begin
      write_q  <= req_write;
      addr_q   <= req_addr;
      len16_q  <= req_len16;
      wdata_q  <= req_wdata;
      byte_sel <= 1'b0;
    end else if ((state == ST_RECOVER) && timer_done && more_bytes) begin
      byte_sel <= 1'b1;
    end
  end

  // Response path. Read data is captured on the last strobe cycle, while the
  // chip is still driving the bus. resp_rdata/resp_err are cleared or set at
  // accept and otherwise hold, so they stay readable until the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= 16'h0000;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= last_byte_done;
      if (accept) begin
        resp_rdata <= 16'h0000;
        resp_err   <= illegal_req;
        resp_valid <= illegal_req;
      end else if ((state == ST_STROBE) && timer_done && !write_q) begin
        if (byte_sel) begin
          resp_rdata[15:8] <= d_in;
        end else begin
          resp_rdata[7:0] <= d_in;
        end
      end
    end
  end

  // Bus pins are decoded straight from registered state so that the async
  // reset releases every strobe in the same instant it is asserted.
  assign bus_active = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);

  assign cs_n  = !bus_active;
  assign wr_n  = !((state == ST_STROBE) && write_q);
  assign rd_n  = !((state == ST_STROBE) && !write_q);
  assign a     = addr_q;
  assign d_oe  = bus_active && write_q;
  assign d_out = d_oe ? (byte_sel ? wdata_q[15:8] : wdata_q[7:0]) : 8'h00;

endmodule

// File: tb/tb_i8254_bus_master.sv
// ---------------------------------------------------------------------------
// tb_i8254_bus_master
// Directed bench for the 8254 bus initiator: control write, 16-bit count
// write, 8/16-bit reads, illegal requests, back-to-back requests and reset
// in the middle of a write strobe. A bus monitor checks protocol rules and
// strobe widths on every cycle.
// ---------------------------------------------------------------------------
module tb_i8254_bus_master;
  import i8254_bus_master_pkg::*;

  localparam int SETUP_CYC  = 1;
  localparam int STROBE_CYC = 2;
  localparam int HOLD_CYC   = 1;
  localparam int RECOV_CYC  = 2;
  localparam int BYTE_T     = SETUP_CYC + STROBE_CYC + HOLD_CYC + RECOV_CYC;
  localparam int CS_W       = SETUP_CYC + STROBE_CYC + HOLD_CYC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_addr = 2'd0;
  logic        req_len16 = 1'b0;
  logic [15:0] req_wdata = 16'h0000;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        cs_n;
  logic        rd_n;
  logic        wr_n;
  logic [1:0]  a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Bus monitor state
  int cs_low, cs_pulses, wr_pulses, rd_pulses, doe_cycles, resp_cnt, rd_idx;
  int cs_w, wr_w, rd_w, cs_gap, gap_last;
  logic [7:0] wr_bytes [4];
  logic [1:0] wr_addr [4];
  logic prev_cs, prev_wr, prev_rd;

  i8254_bus_master #(
    .SETUP_CYC  (SETUP_CYC),
    .STROBE_CYC (STROBE_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .RECOV_CYC  (RECOV_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_len16  (req_len16),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .cs_n       (cs_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .a          (a),
    .d_out      (d_out),
    .d_oe       (d_oe),
    .d_in       (d_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Chip model: first read byte is CD, every later one AB
  assign d_in = (rd_idx == 0) ? 8'hCD : 8'hAB;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Protocol rules and strobe widths, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs = 1'b1;
      prev_wr = 1'b1;
      prev_rd = 1'b1;
      cs_w    = 0;
      wr_w    = 0;
      rd_w    = 0;
      cs_gap  = 0;
    end else begin
      checkOutput("no_overlap", 32'(!rd_n && !wr_n), 0);
      checkOutput("strobe_cs", 32'((!rd_n || !wr_n) && cs_n), 0);
      checkOutput("doe_read", 32'(d_oe && !rd_n), 0);
      if (resp_valid) resp_cnt++;
      if (d_oe) doe_cycles++;
      if (!cs_n) begin
        if (prev_cs) begin
          gap_last = cs_gap;
          cs_pulses++;
        end
        cs_low++;
        cs_w++;
      end else begin
        if (!prev_cs) begin
          checkOutput("cs_width", cs_w, CS_W);
          cs_w   = 0;
          cs_gap = 0;
        end
        cs_gap++;
      end
      if (!wr_n) begin
        if (prev_wr) begin
          if (wr_pulses < 4) begin
            wr_bytes[wr_pulses] = d_out;
            wr_addr[wr_pulses]  = a;
          end
          wr_pulses++;
        end
        wr_w++;
      end else if (!prev_wr) begin
        checkOutput("wr_width", wr_w, STROBE_CYC);
        wr_w = 0;
      end
      if (!rd_n) begin
        if (prev_rd) rd_pulses++;
        rd_w++;
      end else if (!prev_rd) begin
        checkOutput("rd_width", rd_w, STROBE_CYC);
        rd_w = 0;
        rd_idx++;
      end
      prev_cs = cs_n;
      prev_wr = wr_n;
      prev_rd = rd_n;
    end
  end

  task automatic clearCounters();
    cs_low     = 0;
    cs_pulses  = 0;
    wr_pulses  = 0;
    rd_pulses  = 0;
    doe_cycles = 0;
    resp_cnt   = 0;
    rd_idx     = 0;
    gap_last   = 0;
  endtask

  // Presents one request, returns the cycle number of its accept edge
  task automatic applyStimulus(input logic w, input logic [1:0] ad, input logic l16,
                               input logic [15:0] wd, output int acc);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = ad;
    req_len16 = l16;
    req_wdata = wd;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    if (!req_ready) checkOutput("accept_timeout", 0, 1);
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits for completion and checks that resp_valid is a single-cycle pulse
  task automatic waitResp(input int acc, output int lat, output logic [15:0] rdata,
                          output logic err);
    for (int i = 0; i < 100 && !resp_valid; i++) @(negedge clk);
    if (!resp_valid) checkOutput("resp_timeout", 0, 1);
    lat   = cyc - acc;
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
    checkOutput("rv_pulse", 32'(resp_valid), 0);
    checkOutput("rdata_hold", 32'(resp_rdata), 32'(rdata));
  endtask

  initial begin
    int acc, lat, n, prev_acc;
    logic [15:0] rdata;
    logic err;
    logic [1:0] b2b_addr [3];
    logic [7:0] b2b_data [3];
    b2b_addr[0] = 2'd0; b2b_addr[1] = 2'd1; b2b_addr[2] = 2'd2;
    b2b_data[0] = 8'h11; b2b_data[1] = 8'h22; b2b_data[2] = 8'h33;

    clearCounters();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_cs_n", 32'(cs_n), 1);
    checkOutput("rst_rd_n", 32'(rd_n), 1);
    checkOutput("rst_wr_n", 32'(wr_n), 1);
    checkOutput("rst_d_oe", 32'(d_oe), 0);
    checkOutput("rst_a", 32'(a), 0);
    checkOutput("rst_d_out", 32'(d_out), 0);
    checkOutput("rst_ready", 32'(req_ready), 1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 0);
    checkOutput("rst_rdata", 32'(resp_rdata), 0);
    checkOutput("rst_err", 32'(resp_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] control word write");
    clearCounters();
    applyStimulus(1'b1, ADDR_CTRL, 1'b0, 16'h0036, acc);
    waitResp(acc, lat, rdata, err);
    checkOutput("t1_latency", lat, BYTE_T);
    checkOutput("t1_err", 32'(err), 0);
    checkOutput("t1_rdata", 32'(rdata), 0);
    checkOutput("t1_cs_low", cs_low, 4);
    checkOutput("t1_wr_pulses", wr_pulses, 1);
    checkOutput("t1_byte", 32'(wr_bytes[0]), 32'h36);
    checkOutput("t1_addr", 32'(wr_addr[0]), 3);
    checkOutput("t1_doe_cycles", doe_cycles, 4);

    $display("[TB] 16-bit count write");
    clearCounters();
    applyStimulus(1'b1, 2'd0, 1'b1, 16'h1234, acc);
    waitResp(acc, lat, rdata, err);
    checkOutput("t2_latency", lat, 2 * BYTE_T);
    checkOutput("t2_err", 32'(err), 0);
    checkOutput("t2_wr_pulses", wr_pulses, 2);
    checkOutput("t2_lsb", 32'(wr_bytes[0]), 32'h34);
    checkOutput("t2_msb", 32'(wr_bytes[1]), 32'h12);
    checkOutput("t2_addr0", 32'(wr_addr[0]), 0);
    checkOutput("t2_addr1", 32'(wr_addr[1]), 0);
    checkOutput("t2_cs_pulses", cs_pulses, 2);
    checkOutput("t2_recover_gap", gap_last, RECOV_CYC);

    $display("[TB] 16-bit read");
    clearCounters();
    applyStimulus(1'b0, 2'd2, 1'b1, 16'h0000, acc);
    waitResp(acc, lat, rdata, err);
    checkOutput("t3_latency", lat, 2 * BYTE_T);
    checkOutput("t3_rdata", 32'(rdata), 32'hABCD);
    checkOutput("t3_err", 32'(err), 0);
    checkOutput("t3_rd_pulses", rd_pulses, 2);
    checkOutput("t3_wr_pulses", wr_pulses, 0);
    checkOutput("t3_doe_cycles", doe_cycles, 0);

    $display("[TB] 8-bit read");
    clearCounters();
    applyStimulus(1'b0, 2'd1, 1'b0, 16'h0000, acc);
    waitResp(acc, lat, rdata, err);
    checkOutput("t3b_latency", lat, BYTE_T);
    checkOutput("t3b_rdata", 32'(rdata), 32'h00CD);
    checkOutput("t3b_rd_pulses", rd_pulses, 1);

    $display("[TB] illegal requests");
    clearCounters();
    applyStimulus(1'b0, ADDR_CTRL, 1'b0, 16'h0000, acc);
    waitResp(acc, lat, rdata, err);
    checkOutput("t4_rd_latency", lat, 0);
    checkOutput("t4_rd_err", 32'(err), 1);
    checkOutput("t4_rd_rdata", 32'(rdata), 0);
    applyStimulus(1'b1, ADDR_CTRL, 1'b1, 16'hBEEF, acc);
    waitResp(acc, lat, rdata, err);
    checkOutput("t4_wr16_latency", lat, 0);
    checkOutput("t4_wr16_err", 32'(err), 1);
    checkOutput("t4_cs_pulses", cs_pulses, 0);
    checkOutput("t4_strobes", rd_pulses + wr_pulses, 0);
    checkOutput("t4_resp_cnt", resp_cnt, 2);

    $display("[TB] back-to-back requests");
    clearCounters();
    @(negedge clk);
    n = 0;
    prev_acc = 0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_len16 = 1'b0;
    req_addr  = b2b_addr[0];
    req_wdata = {8'h00, b2b_data[0]};
    for (int i = 0; i < 200 && n < 3; i++) begin
      if (req_ready) begin
        if (n > 0) begin
          checkOutput("t5_rv_at_accept", 32'(resp_valid), 1);
          checkOutput("t5_latency", cyc - prev_acc, BYTE_T);
        end
        prev_acc = cyc + 1;
        n++;
        @(negedge clk);
        if (n < 3) begin
          req_addr  = b2b_addr[n];
          req_wdata = {8'h00, b2b_data[n]};
        end else begin
          req_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    checkOutput("t5_accepted", n, 3);
    req_valid = 1'b0;
    waitResp(prev_acc, lat, rdata, err);
    checkOutput("t5_last_latency", lat, BYTE_T);
    checkOutput("t5_wr_pulses", wr_pulses, 3);
    checkOutput("t5_cs_pulses", cs_pulses, 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_byte", 32'(wr_bytes[i]), 32'(b2b_data[i]));
      checkOutput("t5_addr", 32'(wr_addr[i]), 32'(b2b_addr[i]));
    end

    $display("[TB] reset during write strobe");
    clearCounters();
    applyStimulus(1'b1, 2'd1, 1'b0, 16'h0055, acc);
    for (int i = 0; i < 20 && wr_n; i++) @(negedge clk);
    checkOutput("t6_wr_seen", 32'(wr_n), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_wr_n", 32'(wr_n), 1);
    checkOutput("t6_cs_n", 32'(cs_n), 1);
    checkOutput("t6_rd_n", 32'(rd_n), 1);
    checkOutput("t6_d_oe", 32'(d_oe), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("t6_no_resp", resp_cnt, 0);
    checkOutput("t6_ready", 32'(req_ready), 1);
    clearCounters();
    applyStimulus(1'b1, ADDR_CTRL, 1'b0, 16'h0036, acc);
    waitResp(acc, lat, rdata, err);
    checkOutput("t6_after_latency", lat, BYTE_T);
    checkOutput("t6_after_err", 32'(err), 0);
    checkOutput("t6_after_byte", 32'(wr_bytes[0]), 32'h36);
    checkOutput("t6_after_wr_pulses", wr_pulses, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
